// File: rtl/pgr_fifo_pkg.sv
// Shared constants and width helpers for the pgr stream FIFO.
package pgr_fifo_pkg;

  localparam int DEPTH_MIN = 4;
  localparam int DEPTH_MAX = 1024;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 256;

  function automatic int pgr_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index bits plus one wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return pgr_log2(depth) + 1;
  endfunction

endpackage

// File: rtl/pgr_fifo_out_stage.sv
// Output register of the stream FIFO: loads from memory head or bypassed input, holds under backpressure.
module pgr_fifo_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         bypass_i,
  input  logic         pop_i,
  input  logic [W-1:0] mem_data_i,
  input  logic [W-1:0] in_data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = bypass_i ? in_data_i : mem_data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pgr_stream_fifo.sv
// Ready/valid stream FIFO: D-word register memory plus output register (D+1 words).
// Define PGR_FIFO_WATERMARK_EN to add the level, almost_full and almost_empty ports.
module pgr_stream_fifo
  import pgr_fifo_pkg::*;
#(
  parameter int D        = 16,
  parameter int W        = 8,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         data_in_valid,
  input  logic [W-1:0] data_in,
  output logic         data_in_ready,
  input  logic         data_out_ready,
  output logic [W-1:0] data_out,
  output logic         data_out_valid
`ifdef PGR_FIFO_WATERMARK_EN
  ,
  output logic [ptr_width(D)-1:0] level,
  output logic                    almost_full,
  output logic                    almost_empty
`endif
);

  localparam int AW = pgr_log2(D);
  localparam int PW = ptr_width(D);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic mem_empty, mem_full;
  logic push, pop, out_load, bypass, mem_we, mem_re;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign data_in_ready = ~mem_full & ~flush;
  assign push          = data_in_valid & data_in_ready;
  assign pop           = data_out_valid & data_out_ready;

  // Output register refills whenever it will be free and a word exists anywhere.
  assign out_load = (~data_out_valid | pop) & (~mem_empty | push) & ~flush;
  assign bypass   = mem_empty;
  assign mem_we   = push & ~(out_load & bypass);
  assign mem_re   = out_load & ~mem_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (mem_we) wr_ptr_d = wr_ptr_q + PW'(1);
      if (mem_re) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  pgr_fifo_out_stage #(.W(W)) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .load_i     (out_load),
    .bypass_i   (bypass),
    .pop_i      (pop),
    .mem_data_i (mem_q[rd_ptr_q[AW-1:0]]),
    .in_data_i  (data_in),
    .data_o     (data_out),
    .valid_o    (data_out_valid)
  );

`ifdef PGR_FIFO_WATERMARK_EN
  logic [PW-1:0] level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (flush) level_d = '0;
    else       level_d = level_q + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level        = level_q;
  assign almost_full  = (level_q >= PW'(AF_LEVEL));
  assign almost_empty = (level_q <= PW'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_pgr_stream_fifo.sv
// Scoreboard bench for pgr_stream_fifo (D=8, W=16, AF_LEVEL=6, AE_LEVEL=2).
module tb_pgr_stream_fifo;

  localparam int D  = 8;
  localparam int W  = 16;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         data_in_valid = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_in_ready;
  logic         data_out_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_out_valid;
`ifdef PGR_FIFO_WATERMARK_EN
  logic [3:0]   level;
  logic         almost_full;
  logic         almost_empty;
`endif

  pgr_stream_fifo #(.D(D), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
`ifdef PGR_FIFO_WATERMARK_EN
    ,
    .level          (level),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pops     = 0;
  logic [W-1:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, update the model, advance past the edge.
  task automatic step();
    int  n;
    bit  push_acc, pop_acc;
    @(negedge clk);
    n = sb.size();
    check_eq("ready", {31'b0, data_in_ready}, {31'b0, (!flush && n < D + 1)});
    check_eq("valid", {31'b0, data_out_valid}, {31'b0, (n > 0)});
    if (n > 0) check_eq("data_out", {16'b0, data_out}, {16'b0, sb[0]});
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq("level", {28'b0, level}, n);
    check_eq("almost_full", {31'b0, almost_full}, {31'b0, (n >= AF)});
    check_eq("almost_empty", {31'b0, almost_empty}, {31'b0, (n <= AE)});
`endif
    push_acc = data_in_valid && !flush && (n < D + 1);
    pop_acc  = data_out_ready && !flush && (n > 0);
    if (flush) begin
      sb.delete();
    end else begin
      if (pop_acc) begin
        void'(sb.pop_front());
        pops++;
      end
      if (push_acc) sb.push_back(data_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    flush          = f;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'b0, data_out_valid}, 32'd0);
    check_eq({tag, "_data"}, {16'b0, data_out}, 32'd0);
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq({tag, "_level"}, {28'b0, level}, 32'd0);
    check_eq({tag, "_af"}, {31'b0, almost_full}, 32'd0);
    check_eq({tag, "_ae"}, {31'b0, almost_empty}, 32'd1);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", {31'b0, data_in_ready}, 32'd1);

    // Single push, no downstream ready: bypass shows it one cycle later.
    drive(1, 16'h1234, 0, 0);
    step();
    drive(0, 0, 0, 0);
    check_eq("bypass_valid", {31'b0, data_out_valid}, 32'd1);
    check_eq("bypass_data", {16'b0, data_out}, 32'h1234);
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq("bypass_level", {28'b0, level}, 32'd1);
`endif
    step();

    // Fill 0..9 with backpressure: 9 accepted, head held at 0.
    drive(0, 0, 0, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(i), 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    check_eq("full_ready", {31'b0, data_in_ready}, 32'd0);
    check_eq("full_head", {16'b0, data_out}, 32'd0);
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq("full_level", {28'b0, level}, 32'd9);
`endif
    step();

    // One pop from full with a push pending: push stays blocked that cycle.
    drive(1, 16'h00AA, 1, 0);
    step();
    drive(0, 0, 0, 0);
    check_eq("pop_head", {16'b0, data_out}, 32'd1);
    check_eq("pop_ready", {31'b0, data_in_ready}, 32'd1);
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq("pop_level", {28'b0, level}, 32'd8);
`endif
    step();

    // Drain completely, watching the watermarks on the way down.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0);
      step();
    end

    // Continuous streaming of 100 words.
    drive(0, 0, 0, 1);
    step();
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      drive(1, 16'(i), 1, 0);
      step();
    end
    drive(0, 0, 1, 0);
    step();
    check_eq("stream_pops", pops - p0, 32'd100);
    check_eq("stream_empty", {31'b0, data_out_valid}, 32'd0);

    // Flush at level 5 together with a push of 0xBEEF.
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h0100 + i), 0, 0);
      step();
    end
    drive(1, 16'hBEEF, 1, 1);
    step();
    drive(0, 0, 1, 0);
    check_eq("flush_valid", {31'b0, data_out_valid}, 32'd0);
`ifdef PGR_FIFO_WATERMARK_EN
    check_eq("flush_level", {28'b0, level}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) step();

    // Fill to AF_LEVEL then drain.
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'(16'h0200 + i), 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0);
      step();
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
      step();
    end

    // Asynchronous reset in the middle of a busy stream.
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'(16'h0300 + i), 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      step();
    end
    drive(1, 16'h5A5A, 1, 0);
    step();
    drive(0, 0, 1, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
